// File: rtl/keypad_pkg.sv
// Shared types and key-map helpers for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    RELEASE  = 2'd2
  } kp_state_t;

  localparam logic [3:0] KEY_CLEAR  = 4'd12;
  localparam logic [3:0] KEY_COMMIT = 4'd14;

  // Hex value of each key position; the '*' and '#' slots carry no digit.
  function automatic logic [3:0] key_digit(input logic [3:0] code);
    logic [3:0] d;
    case (code)
      4'd0:    d = 4'h1;
      4'd1:    d = 4'h2;
      4'd2:    d = 4'h3;
      4'd3:    d = 4'hA;
      4'd4:    d = 4'h4;
      4'd5:    d = 4'h5;
      4'd6:    d = 4'h6;
      4'd7:    d = 4'hB;
      4'd8:    d = 4'h7;
      4'd9:    d = 4'h8;
      4'd10:   d = 4'h9;
      4'd11:   d = 4'hC;
      4'd13:   d = 4'h0;
      4'd15:   d = 4'hD;
      default: d = 4'h0;
    endcase
    return d;
  endfunction

  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
    logic [1:0] r;
    if (!rows[0])      r = 2'd0;
    else if (!rows[1]) r = 2'd1;
    else if (!rows[2]) r = 2'd2;
    else               r = 2'd3;
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Row synchroniser plus a counter of consecutive cycles the synchronised rows
// match a reference pattern supplied by the scanner FSM.
module key_debounce #(
  parameter logic [19:0] DEBOUNCE_CNT = 20'd500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_row,
  input  logic [3:0] ref_rows,
  input  logic       clr,
  output logic [3:0] row_sync,
  output logic       changed,
  output logic       held
);

  logic [3:0]  sync1_q, sync2_q;
  logic [19:0] cnt_q, cnt_d;
  logic        match;

  always_comb begin
    match   = (sync2_q == ref_rows);
    changed = !match;
    // held fires on the cycle that completes DEBOUNCE_CNT matching cycles
    held    = match && (cnt_q == DEBOUNCE_CNT - 20'd1);
    cnt_d   = cnt_q;
    if (clr || !match) cnt_d = '0;
    else               cnt_d = cnt_q + 20'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_row;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
    end
  end

  assign row_sync = sync2_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with debounce, hex entry register and a
// valid/ready handshake that hands committed entries to the CPU.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV     = 16'd50000,
  parameter logic [19:0] DEBOUNCE_CNT = 20'd500000,
  parameter int          NUM_DIGITS   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [3:0]                key_row,
  output logic [3:0]                key_col,
  output logic                      key_event,
  output logic [3:0]                key_code,
  output logic [4*NUM_DIGITS-1:0]   entry_data,
  output logic                      entry_valid,
  input  logic                      entry_ready
);

  localparam int ENTRY_W = 4 * NUM_DIGITS;

  kp_state_t          state_q, state_d;
  logic [1:0]         col_q, col_d;
  logic [15:0]        div_q, div_d;
  logic [3:0]         rec_rows_q, rec_rows_d;
  logic               key_event_q, key_event_d;
  logic [3:0]         key_code_q, key_code_d;
  logic [ENTRY_W-1:0] entry_data_q, entry_data_d;
  logic               entry_valid_q, entry_valid_d;

  logic [3:0] row_sync, ref_rows;
  logic       db_clr, db_changed, db_held;

  // RELEASE waits for an all-high pattern; DEBOUNCE for the recorded press.
  assign ref_rows = (state_q == RELEASE) ? 4'hF : rec_rows_q;
  assign db_clr   = (state_q == SCAN) || ((state_q == DEBOUNCE) && db_held);

  key_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_row  (key_row),
    .ref_rows (ref_rows),
    .clr      (db_clr),
    .row_sync (row_sync),
    .changed  (db_changed),
    .held     (db_held)
  );

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    div_d       = div_q;
    rec_rows_d  = rec_rows_q;
    key_event_d = 1'b0;
    key_code_d  = key_code_q;
    case (state_q)
      SCAN: begin
        if (div_q == SCAN_DIV - 16'd1) begin
          div_d = '0;
          if (row_sync != 4'hF) begin
            rec_rows_d = row_sync;
            state_d    = DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      DEBOUNCE: begin
        if (db_changed) begin
          state_d = SCAN;
          col_d   = col_q + 2'd1;
          div_d   = '0;
        end else if (db_held) begin
          key_event_d = 1'b1;
          key_code_d  = {lowest_low_row(rec_rows_q), col_q};
          state_d     = RELEASE;
        end
      end
      RELEASE: begin
        if (db_held) begin
          state_d = SCAN;
          col_d   = col_q + 2'd1;
          div_d   = '0;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // A transfer takes priority; key events only land while nothing is committed.
  always_comb begin
    entry_data_d  = entry_data_q;
    entry_valid_d = entry_valid_q;
    if (entry_valid_q && entry_ready) begin
      entry_valid_d = 1'b0;
      entry_data_d  = '0;
    end else if (key_event_q && !entry_valid_q) begin
      case (key_code_q)
        KEY_CLEAR:  entry_data_d  = '0;
        KEY_COMMIT: entry_valid_d = 1'b1;
        default:    entry_data_d  = {entry_data_q[ENTRY_W-5:0], key_digit(key_code_q)};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SCAN;
      col_q         <= 2'd0;
      div_q         <= '0;
      rec_rows_q    <= 4'hF;
      key_event_q   <= 1'b0;
      key_code_q    <= 4'd0;
      entry_data_q  <= '0;
      entry_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      div_q         <= div_d;
      rec_rows_q    <= rec_rows_d;
      key_event_q   <= key_event_d;
      key_code_q    <= key_code_d;
      entry_data_q  <= entry_data_d;
      entry_valid_q <= entry_valid_d;
    end
  end

  assign key_col     = ~(4'b0001 << col_q);
  assign key_event   = key_event_q;
  assign key_code    = key_code_q;
  assign entry_data  = entry_data_q;
  assign entry_valid = entry_valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a modelled key matrix drives the rows and a
// key-map/entry model predicts events and the entry word.
module tb_keypad_scanner;
  import keypad_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  key_row;
  logic [3:0]  key_col;
  logic        key_event;
  logic [3:0]  key_code;
  logic [31:0] entry_data;
  logic        entry_valid;
  logic        entry_ready = 1'b0;

  logic [15:0] pressed = '0;
  int          checks = 0;
  int          failures = 0;
  int          ev_cnt = 0;
  logic [3:0]  ev_code = '0;
  logic [31:0] exp_data = '0;
  logic        exp_valid = 1'b0;
  string       layout = "123A456B789C*0#D";

  keypad_scanner #(.SCAN_DIV(16'd4), .DEBOUNCE_CNT(20'd8), .NUM_DIGITS(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_row     (key_row),
    .key_col     (key_col),
    .key_event   (key_event),
    .key_code    (key_code),
    .entry_data  (entry_data),
    .entry_valid (entry_valid),
    .entry_ready (entry_ready)
  );

  always #5 clk = ~clk;

  // Key matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    key_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !key_col[c]) key_row[r] = 1'b0;
  end

  always @(posedge clk) begin
    if (key_event === 1'b1) begin
      ev_cnt  <= ev_cnt + 1;
      ev_code <= key_code;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_key(input int code);
    byte ch;
    int  d;
    ch = layout[code];
    if (exp_valid) return;
    if (ch == "*")      exp_data = 32'h0;
    else if (ch == "#") exp_valid = 1'b1;
    else begin
      if (ch >= "0" && ch <= "9") d = ch - "0";
      else                        d = ch - "A" + 10;
      exp_data = exp_data * 16 + d;
    end
  endfunction

  task automatic tap(input int code, input int hold, input int rel);
    @(negedge clk);
    pressed[code] = 1'b1;
    repeat (hold) @(negedge clk);
    pressed[code] = 1'b0;
    repeat (rel) @(negedge clk);
    model_key(code);
  endtask

  task automatic pulse_ready();
    @(negedge clk);
    entry_ready = 1'b1;
    @(negedge clk);
    entry_ready = 1'b0;
    if (exp_valid) begin
      exp_valid = 1'b0;
      exp_data  = 32'h0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (key_col !== 4'b1110 || key_event !== 1'b0 || key_code !== 4'd0 ||
        entry_data !== 32'h0 || entry_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: col=%b ev=%b code=%0d data=%h valid=%b, required col=1110 ev=0 code=0 data=0 valid=0",
               key_col, key_event, key_code, entry_data, entry_valid);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_press();
    int  e0 = ev_cnt;
    bit  moved = 0;
    bit  early = 0;
    @(negedge clk);
    pressed[5] = 1'b1;
    repeat (60) @(negedge clk);
    checks++;
    if (key_col !== 4'b1101) begin
      failures++;
      $display("FAIL hold_col_frozen: got %b, required 1101", key_col);
    end
    pressed[5] = 1'b0;
    model_key(5);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (key_col !== 4'b1101) early = 1;
    end
    for (int i = 0; i < 20 && !moved; i++) begin
      @(negedge clk);
      if (key_col !== 4'b1101) moved = 1;
    end
    checks++;
    if (early || !moved) begin
      failures++;
      $display("FAIL release_rescan: left_early=%0d resumed=%0d, required 0 and 1", early, moved);
    end
    checks++;
    if (ev_cnt !== e0 + 1 || ev_code !== 4'd5 || key_code !== 4'd5) begin
      failures++;
      $display("FAIL single_press_event: events=%0d code=%0d held_code=%0d, required 1 5 5",
               ev_cnt - e0, ev_code, key_code);
    end
    checks++;
    if (entry_data !== exp_data) begin
      failures++;
      $display("FAIL single_press_data: got %h, required %h", entry_data, exp_data);
    end
  endtask

  task automatic test_glitch();
    int e0 = ev_cnt;
    bit found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (key_col === 4'b1101) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL glitch_col1_wait: col1 never driven, last col=%b", key_col);
    end
    for (int k = 0; k < 3; k++) begin
      pressed[5] = 1'b1;
      repeat (5) @(negedge clk);
      pressed[5] = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (ev_cnt !== e0 || entry_data !== exp_data) begin
      failures++;
      $display("FAIL glitch_no_event: events=%0d data=%h, required 0 %h", ev_cnt - e0, entry_data, exp_data);
    end
  endtask

  task automatic test_commit_handshake();
    int e0;
    tap(12, 60, 30);
    tap(0, 60, 30);
    tap(1, 60, 30);
    tap(2, 60, 30);
    tap(14, 60, 30);
    checks++;
    if (entry_valid !== exp_valid || entry_data !== exp_data) begin
      failures++;
      $display("FAIL commit: valid=%b data=%h, required %b %h", entry_valid, entry_data, exp_valid, exp_data);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (entry_valid !== 1'b1 || entry_data !== exp_data) begin
      failures++;
      $display("FAIL commit_hold: valid=%b data=%h, required 1 %h", entry_valid, entry_data, exp_data);
    end
    e0 = ev_cnt;
    tap(8, 60, 30);
    checks++;
    if (ev_cnt !== e0 + 1 || key_code !== 4'd8 || entry_data !== exp_data || entry_valid !== 1'b1) begin
      failures++;
      $display("FAIL key_while_valid: events=%0d code=%0d data=%h valid=%b, required 1 8 %h 1",
               ev_cnt - e0, key_code, entry_data, entry_valid, exp_data);
    end
    pulse_ready();
    checks++;
    if (entry_valid !== 1'b0 || entry_data !== 32'h0) begin
      failures++;
      $display("FAIL transfer: valid=%b data=%h, required 0 00000000", entry_valid, entry_data);
    end
    tap(13, 60, 30);
    @(negedge clk);
    entry_ready = 1'b1;
    repeat (5) @(negedge clk);
    entry_ready = 1'b0;
    tap(15, 60, 30);
    checks++;
    if (entry_valid !== 1'b0 || entry_data !== exp_data) begin
      failures++;
      $display("FAIL ready_when_idle: valid=%b data=%h, required 0 %h", entry_valid, entry_data, exp_data);
    end
  endtask

  task automatic test_nine_digits_clear();
    int codes[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    foreach (codes[i]) tap(codes[i], 60, 30);
    checks++;
    if (entry_data !== exp_data) begin
      failures++;
      $display("FAIL nine_digits: got %h, required %h", entry_data, exp_data);
    end
    tap(12, 60, 30);
    checks++;
    if (entry_data !== 32'h0) begin
      failures++;
      $display("FAIL clear: got %h, required 00000000", entry_data);
    end
  endtask

  task automatic test_random_entry();
    for (int round = 0; round < 2; round++) begin
      int n = $urandom_range(3, 10);
      for (int i = 0; i < n; i++) begin
        int code;
        int e0 = ev_cnt;
        do code = $urandom_range(0, 15); while (code == 14);
        tap(code, 50 + $urandom_range(0, 15), 25 + $urandom_range(0, 10));
        checks++;
        if (ev_cnt !== e0 + 1 || key_code !== code[3:0] || entry_data !== exp_data) begin
          failures++;
          $display("FAIL random_key: events=%0d code=%0d data=%h, required 1 %0d %h",
                   ev_cnt - e0, key_code, entry_data, code, exp_data);
        end
      end
      tap(14, 60, 30);
      repeat ($urandom_range(0, 6)) @(negedge clk);
      checks++;
      if (entry_valid !== 1'b1 || entry_data !== exp_data) begin
        failures++;
        $display("FAIL random_commit: valid=%b data=%h, required 1 %h", entry_valid, entry_data, exp_data);
      end
      pulse_ready();
      checks++;
      if (entry_valid !== 1'b0 || entry_data !== 32'h0) begin
        failures++;
        $display("FAIL random_transfer: valid=%b data=%h, required 0 00000000", entry_valid, entry_data);
      end
    end
  endtask

  task automatic test_multi_key();
    int e0 = ev_cnt;
    @(negedge clk);
    pressed[2]  = 1'b1;
    pressed[10] = 1'b1;
    repeat (60) @(negedge clk);
    pressed[2]  = 1'b0;
    pressed[10] = 1'b0;
    repeat (30) @(negedge clk);
    model_key(2);
    checks++;
    if (ev_cnt !== e0 + 1 || ev_code !== 4'd2 || entry_data !== exp_data) begin
      failures++;
      $display("FAIL multi_key: events=%0d code=%0d data=%h, required 1 2 %h",
               ev_cnt - e0, ev_code, entry_data, exp_data);
    end
  endtask

  task automatic test_zero_commit();
    tap(12, 60, 30);
    tap(14, 60, 30);
    checks++;
    if (entry_valid !== 1'b1 || entry_data !== 32'h0) begin
      failures++;
      $display("FAIL zero_commit: valid=%b data=%h, required 1 00000000", entry_valid, entry_data);
    end
    pulse_ready();
    checks++;
    if (entry_valid !== 1'b0) begin
      failures++;
      $display("FAIL zero_transfer: valid=%b, required 0", entry_valid);
    end
  endtask

  task automatic test_reset_midway();
    bit found = 0;
    int e0;
    tap(3, 60, 30);
    checks++;
    if (entry_data !== exp_data) begin
      failures++;
      $display("FAIL pre_reset_data: got %h, required %h", entry_data, exp_data);
    end
    pressed[9] = 1'b1;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (dut.state_q == DEBOUNCE) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL reach_debounce: state never DEBOUNCE within 200 cycles");
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_data  = 32'h0;
    exp_valid = 1'b0;
    checks++;
    if (key_col !== 4'b1110 || entry_data !== 32'h0 || key_event !== 1'b0 || entry_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: col=%b data=%h ev=%b valid=%b, required 1110 00000000 0 0",
               key_col, entry_data, key_event, entry_valid);
    end
    @(negedge clk);
    pressed = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    e0 = ev_cnt;
    repeat (100) @(negedge clk);
    checks++;
    if (ev_cnt !== e0 || entry_data !== 32'h0 || key_code !== 4'd0) begin
      failures++;
      $display("FAIL post_reset_idle: events=%0d data=%h code=%0d, required 0 00000000 0",
               ev_cnt - e0, entry_data, key_code);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_commit_handshake();
    test_nine_digits_clear();
    test_random_entry();
    test_multi_key();
    test_zero_commit();
    test_reset_midway();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
